// File: rtl/pipe_stage.sv
// Inter-stage pipeline register with valid/ready handshake,
// one-entry skid buffer, synchronous flush and control-bit bubble masking.
module pipe_stage #(
   parameter int                DATA_W    = 136,
   parameter int                CTRL_W    = 5,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occ_o
);

   logic              main_v;
   logic              skid_v;
   logic [DATA_W-1:0] main_d;
   logic [DATA_W-1:0] skid_d;
   logic              push;
   logic              pop;
   logic              main_v_nxt;
   logic              skid_v_nxt;
   logic              load_main_in;
   logic              load_main_skid;
   logic              load_skid;
   logic [DATA_W-1:0] mask;

   assign push = in_valid_i & ~skid_v;
   assign pop  = main_v & out_ready_i;

   assign in_ready_o  = ~skid_v;
   assign out_valid_o = main_v;
   assign occ_o       = {1'b0, main_v} + {1'b0, skid_v};

   // Data moves only on real transitions; a flush clears valids but keeps data
   assign load_main_in   = ~flush_i & push & (~main_v | pop);
   assign load_main_skid = ~flush_i & skid_v & pop;
   assign load_skid      = ~flush_i & push & main_v & ~pop;

   always_comb begin
      main_v_nxt = main_v;
      skid_v_nxt = skid_v;
      if (flush_i) begin
         main_v_nxt = 1'b0;
         skid_v_nxt = 1'b0;
      end else if (skid_v) begin
         main_v_nxt = 1'b1;
         skid_v_nxt = ~pop;
      end else if (main_v) begin
         main_v_nxt = ~pop | push;
         skid_v_nxt = push & ~pop;
      end else begin
         main_v_nxt = push;
         skid_v_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
      end else begin
         main_v <= main_v_nxt;
         skid_v <= skid_v_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_d <= RESET_VAL;
      end else if (load_main_skid) begin
         main_d <= skid_d;
      end else if (load_main_in) begin
         main_d <= in_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_d <= RESET_VAL;
      end else if (load_skid) begin
         skid_d <= in_data_i;
      end
   end

   always_comb begin
      mask = '1;
      for (int i = 0; i < DATA_W; i++) begin
         if (i < CTRL_W) mask[i] = main_v;
      end
   end

   assign out_data_o = main_d & mask;

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: directed scenarios then a random run,
// with an independent monitor checking order, occupancy and stall stability.
module tb_pipe_stage;

   localparam int DW = 136;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [1:0]    occ;

   logic [DW-1:0] q[$];
   int            total = 0;
   int            passed = 0;
   int            delivered = 0;

   pipe_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_data_i  (in_data),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_data),
      .occ_o      (occ)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Drive one cycle; record expected payload once the edge has taken it
   task automatic step(input logic v, input logic [DW-1:0] d,
                       input logic r, input logic f);
      logic took;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      @(negedge clk);
      took = v && in_ready && !f;
      @(posedge clk);
      #1;
      if (took) q.push_back(d);
   endtask

   // Monitor
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_d;
   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (rst_n) begin
         chk("occ", DW'(occ), DW'(q.size()));
         chk("valid", DW'(out_valid), DW'(q.size() != 0));
         if (prev_stall) begin
            chk("stall_valid", DW'(out_valid), DW'(1));
            chk("stall_data", out_data, prev_d);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               total++;
               $display("FAIL pop_empty: got %h expected no output", out_data);
            end else begin
               e = q.pop_front();
               chk("order", out_data, e);
               delivered++;
            end
         end
         if (flush) q.delete();
         prev_stall = out_valid && !out_ready && !flush;
         prev_d     = out_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      int d0;
      logic [159:0] r160;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #12;
      chk("rst_data", out_data, '0);
      chk("rst_valid", DW'(out_valid), DW'(0));
      chk("rst_ready", DW'(in_ready), DW'(1));
      chk("rst_occ", DW'(occ), DW'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // streaming
      step(1'b1, DW'('h11), 1'b1, 1'b0);
      chk("s1", out_data, DW'('h11));
      chk("s1_occ", DW'(occ), DW'(1));
      step(1'b1, DW'('h22), 1'b1, 1'b0);
      chk("s2", out_data, DW'('h22));
      chk("s2_occ", DW'(occ), DW'(1));
      step(1'b1, DW'('h33), 1'b1, 1'b0);
      chk("s3", out_data, DW'('h33));
      chk("s3_occ", DW'(occ), DW'(1));
      step(1'b0, '0, 1'b1, 1'b0);
      chk("s_empty", DW'(out_valid), DW'(0));

      // stall and skid
      step(1'b1, DW'('hA0), 1'b0, 1'b0);
      step(1'b1, DW'('hB0), 1'b0, 1'b0);
      chk("skid_occ", DW'(occ), DW'(2));
      chk("skid_ready", DW'(in_ready), DW'(0));
      step(1'b1, DW'('hC0), 1'b0, 1'b0);
      chk("skid_hold", out_data, DW'('hA0));
      step(1'b1, DW'('hC0), 1'b1, 1'b0);
      chk("skid_b", out_data, DW'('hB0));
      chk("skid_b_occ", DW'(occ), DW'(1));
      step(1'b1, DW'('hC0), 1'b1, 1'b0);
      chk("skid_c", out_data, DW'('hC0));
      step(1'b0, '0, 1'b1, 1'b0);
      chk("skid_empty", DW'(occ), DW'(0));

      // flush in FULL with in_valid
      step(1'b1, DW'('hD0), 1'b0, 1'b0);
      step(1'b1, DW'('hE0), 1'b0, 1'b0);
      step(1'b1, DW'('hF0), 1'b0, 1'b1);
      chk("fl_occ", DW'(occ), DW'(0));
      chk("fl_valid", DW'(out_valid), DW'(0));
      chk("fl_ready", DW'(in_ready), DW'(1));

      // flush in BUSY drops an otherwise accepted payload
      step(1'b1, DW'('h140), 1'b0, 1'b0);
      step(1'b1, DW'('h260), 1'b0, 1'b1);
      chk("fl2_occ", DW'(occ), DW'(0));
      chk("fl2_held", out_data, DW'('h140));

      // flush with pop in BUSY
      step(1'b1, DW'('h3A0), 1'b0, 1'b0);
      d0 = delivered;
      step(1'b0, '0, 1'b1, 1'b1);
      chk("fl_pop_delivered", DW'(delivered), DW'(d0 + 1));
      chk("fl_pop_occ", DW'(occ), DW'(0));

      // bubble mask
      step(1'b1, DW'('hDEAD_BEEF_FF), 1'b0, 1'b0);
      chk("mask_valid_data", out_data, DW'('hDEAD_BEEF_FF));
      step(1'b0, '0, 1'b0, 1'b1);
      chk("mask_data", out_data, DW'('hDEAD_BEEF_E0));
      chk("mask_valid", DW'(out_valid), DW'(0));

      // asynchronous reset mid-FULL
      step(1'b1, DW'('h5A5), 1'b0, 1'b0);
      step(1'b1, DW'('h6B6), 1'b0, 1'b0);
      chk("ar_full", DW'(occ), DW'(2));
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("ar_valid", DW'(out_valid), DW'(0));
      chk("ar_ready", DW'(in_ready), DW'(1));
      chk("ar_occ", DW'(occ), DW'(0));
      chk("ar_data", out_data, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("ar_post_data", out_data, '0);

      // random run
      for (int i = 0; i < 10000; i++) begin
         r160 = {$urandom, $urandom, $urandom, $urandom, $urandom};
         step(1'($urandom_range(0, 1)), r160[DW-1:0],
              1'($urandom_range(0, 1)), $urandom_range(0, 99) < 2);
      end
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
      chk("drain", DW'(q.size()), DW'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised inter-stage pipeline register for the CPU datapath, carrying one stage's payload to the next (IF/ID, ID/EX, EX/MEM or MEM/WB). It adds a valid/ready handshake, a one-entry skid buffer so that `in_ready_o` comes straight from a flop, synchronous flush for branch and exception kill, and bubble masking of control bits. It replaces the fixed, always-advancing stage registers.

## Interface
- `DATA_W`, default 136: payload width in bits.
- `CTRL_W`, default 5: number of low-order payload bits that are control (reg_we, mem_write, reg_write select). These bits are forced to 0 whenever `out_valid_o` = 0. Range 0..`DATA_W`.
- `RESET_VAL`, default 0: `DATA_W`-bit reset value of both storage entries.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush_i` input 1: synchronous kill of all held and incoming entries.
- `in_valid_i` input 1: upstream has a payload.
- `in_ready_o` output 1: stage can accept. Driven only by flop state.
- `in_data_i` input `DATA_W`: upstream payload.
- `out_valid_o` output 1: the main entry is valid.
- `out_ready_i` input 1: downstream consumes this cycle.
- `out_data_o` output `DATA_W`: main entry payload. Bits [`CTRL_W`-1:0] are zero when invalid.
- `occ_o` output 2: occupancy, 0, 1 or 2.

## Operation
- Storage: a main entry (`main_v`, `main_d`) and a skid entry (`skid_v`, `skid_d`). Output always comes from main. Ordering is FIFO.
- Definitions:
  - push = `in_valid_i` & `in_ready_o`.
  - pop = `out_valid_o` & `out_ready_i`.
- State is encoded by {`skid_v`, `main_v`}:
  - EMPTY = 00.
  - BUSY = 01.
  - FULL = 11.
  - State 10 is illegal and never reached.
- Outputs:
  - `in_ready_o` = ~`skid_v`.
  - `out_valid_o` = `main_v`.
  - `occ_o` = `main_v` + `skid_v`.
- Transitions when `flush_i` = 0:
  - EMPTY, push: main <= in, go to BUSY. No push: stay.
  - BUSY, push & pop: main <= in, stay BUSY.
  - BUSY, push & ~pop: skid <= in, go to FULL.
  - BUSY, ~push & pop: go to EMPTY.
  - BUSY, neither push nor pop: hold.
  - FULL: `in_ready_o` = 0, so no push. Pop: main <= skid, go to BUSY. No pop: hold.
- Flush (`flush_i` = 1) overrides everything:
  - Next state is EMPTY. The incoming payload is dropped even if push is high.
  - A pop in the flush cycle is still a completed transfer, because downstream has sampled it.
- Data registers load only on the transitions listed above. Otherwise they hold, including across flush; only the valid bits clear.
- Bubble masking: `out_data_o`[`CTRL_W`-1:0] = `main_d`[`CTRL_W`-1:0] & {`CTRL_W`{`main_v`}}. The upper bits pass through unmasked.
- With `CTRL_W` = 0, no bits are masked.
- Stall is expressed by `out_ready_i` = 0. The stage holds its output stable: `out_data_o` and `out_valid_o` do not change while `out_valid_o` = 1 and `out_ready_i` = 0, unless `flush_i` = 1.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `main_v` = `skid_v` = 0.
  - `main_d` = `skid_d` = `RESET_VAL`.
  - `out_valid_o` = 0; `occ_o` = 0.
  - `in_ready_o` = 1, during and after reset.
  - `out_data_o` = `RESET_VAL` with the low `CTRL_W` bits zero.
- Reset asserted mid-operation discards both entries immediately, without waiting for a clock edge.
- Latency: a push at edge N into an empty stage gives `out_valid_o` = 1 with that data after edge N.
- Throughput: 1 payload per cycle while `out_ready_i` = 1.
- `in_ready_o` falls the cycle after a push & ~pop in BUSY, and rises the cycle after a pop in FULL. There is no combinational path from `out_ready_i` to `in_ready_o`.
- Flush at edge N: `out_valid_o` = 0 and `in_ready_o` = 1 from N+1.

## Test plan
- **Reset and streaming:** reset, then push 0x11, 0x22, 0x33 on consecutive cycles with `out_ready_i` = 1.
  - Outputs 0x11, 0x22, 0x33 on the next three cycles; `occ_o` stays 1.
  - `out_data_o` = 0 and `out_valid_o` = 0 during reset.
- **Stall and skid:** push A, then push B with `out_ready_i` = 0.
  - `occ_o` = 2 and `in_ready_o` = 0; C is held upstream.
  - Release `out_ready_i`: output A, B, C in order, with no loss or duplicate.
- **Flush:**
  - Flush in FULL with a concurrent `in_valid_i`: next cycle `occ_o` = 0, `out_valid_o` = 0, and the incoming payload is never emitted.
  - Flush with pop in BUSY: the popped item counts as delivered.
- **Bubble mask (`CTRL_W` = 5):** after flush, the held data has low bits 0x1F.
  - `out_data_o`[4:0] = 0 while invalid; the upper bits equal the held data.
- **Asynchronous reset mid-FULL:** assert `rst_n` = 0 between edges.
  - `out_valid_o` = 0 and `in_ready_o` = 1 before the next edge.
  - Data equals `RESET_VAL`.
- **Random run (10k cycles):** random `in_valid_i`, `out_ready_i` and `flush_i` (2%) against a scoreboard model.
  - FIFO order holds, and output is stable under stall.
